pkt_fifo: RTL and testbench
===========================

Name: pkt_fifo

Overview:
Parametrised synchronous packet FIFO for router input ports. It is the successor to the fixed 36-bit × 64 input buffer.
- Adds configurable width and depth, registered grant handshakes, occupancy and almost-full reporting, and sticky error flags.
- Adds an edge-request write mode: one grant per request assertion.
- Sits between the upstream link and the router crossbar or arbiter.

Parameters:
DATA_WIDTH, 36, packet width in bits
DEPTH, 64, number of entries; power of two, minimum 2
AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH
WR_EDGE_MODE, 0, 0 = level (accept every cycle write_req is high); 1 = one accept per write_req assertion

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of FIFO contents
write_req  in  1  upstream write request
PacketIn  in  DATA_WIDTH  write data, sampled on an accepted write
write_gnt  out  1  registered pulse, one per accepted write
read_req  in  1  downstream read request
read_gnt  out  1  registered pulse; PacketOut valid while high
PacketOut  out  DATA_WIDTH  read data
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_THRESH
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky: write request refused because FIFO full
underflow  out  1  sticky: read request refused because FIFO empty

Behaviour:
- Reset (rst_n low, asynchronous): all outputs take these values immediately.
  - Pointers = 0, count = 0, empty = 1, full = 0, almost_full = 0.
  - write_gnt = 0, read_gnt = 0, PacketOut = 0, overflow = 0, underflow = 0.
  - Write-arm flag = 1.
- Pointers are ADDR_W+1 bits, where ADDR_W = $clog2(DEPTH). The MSB is the wrap bit.
  - full = address bits equal AND wrap bits differ.
  - empty = pointers equal.
  - Pointers increment modulo 2^(ADDR_W+1); address wraps naturally from DEPTH-1 to 0.
- Write acceptance: wr_ok = write_req & !full & !flush & (WR_EDGE_MODE==0 | arm).
  - Edge mode: arm clears on an accepted write and re-sets on any cycle with write_req == 0.
  - Level mode: arm is ignored.
- Read acceptance: rd_ok = read_req & !empty & !flush.
- full and empty are evaluated from the pre-edge count. Consequences:
  - Read and write together when empty: write accepted, read refused, underflow set.
  - Read and write together when full: read accepted, write refused, overflow set.
  - Read and write together otherwise: both accepted, count unchanged.
- Latency:
  - write_gnt is high in cycle N+1 for a write accepted in cycle N.
  - Read accepted in cycle N: read_gnt high and PacketOut = entry in cycle N+1. The RAM read is registered.
  - PacketOut holds its last value when read_gnt is low; it is never driven to z.
  - A written entry is readable from the cycle after the write, because empty deasserts then. There is no write-to-read bypass.
- count, empty, full and almost_full update on the edge that performs the access.
- overflow sets when write_req is high and full is high, with the edge-mode arm condition applying.
  - In edge mode, a held request that has already been granted is not an overflow.
- underflow sets when read_req is high and empty is high.
- overflow and underflow clear only on reset or flush.
- flush has priority over both accesses in its cycle.
  - Clears pointers, count and error flags; sets arm = 1; forces grants to 0 in the next cycle.
  - PacketOut holds. RAM contents are don't-care.
- Reset asserted mid-burst: the FIFO is empty on release. The first accepted write after release lands at address 0.
- Parameter checks at elaboration:
  - DEPTH must be a power of two.
  - AF_THRESH must be in 1..DEPTH.

Decomposition:
- router_pkg holds:
  - DATA_WIDTH_DEF = 36 and DEPTH_DEF = 64 (these replace the global dataWidth macro).
  - A function clog2-based width helper.
- One sub-module, pkt_fifo_ram: simple dual-port RAM, DATA_WIDTH × DEPTH.
  - Write port: we, waddr, wdata.
  - Read port: re, raddr; registered q.
  - No reset on storage, so it infers block RAM.
  - Pointer, count, flag and grant logic live in pkt_fifo.

Test Plan:
1. DEPTH=4, level mode: write 0xA, 0xB, 0xC, 0xD on consecutive cycles → write_gnt pulses 4×. count steps 1,2,3,4. full=1 after the 4th write. A 5th write_req sets overflow=1 and produces no write_gnt.
2. Same FIFO, read 4×: read_gnt is high one cycle after each read_req, with PacketOut = 0xA, 0xB, 0xC, 0xD in order. empty=1 after the last read. A further read_req sets underflow=1 and PacketOut stays 0xD.
3. Wrap: 6 write/read pairs interleaved over DEPTH=4 → data emerges in order across address wrap. full is never asserted. Final count = 0.
4. Simultaneous access:
   - At count=2, read and write together → count stays 2, both grants pulse.
   - At empty, read and write together → count=1, underflow=1.
   - At full, read and write together → count=3, overflow=1.
5. WR_EDGE_MODE=1: write_req held high for 5 cycles, then low 1 cycle, then high 1 cycle → exactly 2 write_gnt pulses and count=2. overflow stays 0.
6. flush at count=3, concurrent with write_req, then rst_n pulsed low mid-cycle during a read:
   - flush → count=0, empty=1, flags cleared, no write_gnt.
   - rst_n low → all outputs take reset values immediately without a clock edge.

Source files
------------

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared defaults and width helpers for router input buffering
package router_pkg;

    localparam int DATA_WIDTH_DEF = 36;
    localparam int DEPTH_DEF      = 64;

    // Occupancy needs one extra bit so that a completely full FIFO is representable.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// rtl/pkt_fifo_ram.sv - simple dual-port storage with registered read data
module pkt_fifo_ram #(
    parameter int DATA_WIDTH = 36,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Only the output register is reset; the array stays reset-free to map onto block RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (re) begin
            q <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/pkt_fifo.sv
// rtl/pkt_fifo.sv - router input packet FIFO with registered grants, occupancy and sticky errors
module pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int DEPTH        = DEPTH_DEF,
    parameter int AF_THRESH    = DEPTH - 4,
    parameter int WR_EDGE_MODE = 0
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        write_req,
    input  logic [DATA_WIDTH-1:0]       PacketIn,
    output logic                        write_gnt,
    input  logic                        read_req,
    output logic                        read_gnt,
    output logic [DATA_WIDTH-1:0]       PacketOut,
    output logic                        empty,
    output logic                        full,
    output logic                        almost_full,
    output logic [cnt_width(DEPTH)-1:0] count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = cnt_width(DEPTH);
    localparam logic [ADDR_W:0]  PTR_ONE = 1;
    localparam logic [CNT_W-1:0] AF_T    = CNT_W'(AF_THRESH);
    localparam logic             LEVEL   = (WR_EDGE_MODE == 0);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("pkt_fifo: DEPTH must be a power of two and at least 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $error("pkt_fifo: AF_THRESH must lie in 1..DEPTH");
    end

    logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic            arm_q, arm_d, wgnt_q, rgnt_q, ovf_q, ovf_d, unf_q, unf_d;
    logic            wr_ok, rd_ok, wr_try;

    // Flags come straight from the registered pointers, so they follow reset immediately.
    assign count       = wr_ptr_q - rd_ptr_q;
    assign empty       = (wr_ptr_q == rd_ptr_q);
    assign full        = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0])
                       & (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);
    assign almost_full = (count >= AF_T);

    always_comb begin
        wr_try   = write_req & (LEVEL | arm_q);
        wr_ok    = wr_try & ~full & ~flush;
        rd_ok    = read_req & ~empty & ~flush;
        wr_ptr_d = wr_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = rd_ok ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        ovf_d    = ovf_q | (wr_try & full);
        unf_d    = unf_q | (read_req & empty);
        arm_d    = arm_q;
        if (!write_req) begin
            arm_d = 1'b1;
        end else if (wr_ok) begin
            arm_d = 1'b0;
        end
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            arm_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            arm_q    <= 1'b1;
            wgnt_q   <= 1'b0;
            rgnt_q   <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            arm_q    <= arm_d;
            wgnt_q   <= wr_ok;
            rgnt_q   <= rd_ok;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    assign write_gnt = wgnt_q;
    assign read_gnt  = rgnt_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

    pkt_fifo_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (wr_ok),
        .waddr(wr_ptr_q[ADDR_W-1:0]),
        .wdata(PacketIn),
        .re   (rd_ok),
        .raddr(rd_ptr_q[ADDR_W-1:0]),
        .q    (PacketOut)
    );

endmodule

// File: tb/tb_pkt_fifo.sv
// tb/tb_pkt_fifo.sv - self-checking bench for pkt_fifo in level and edge write modes
module tb_pkt_fifo;

    localparam int DW = 16;
    localparam int DP = 4;

    typedef struct packed {
        logic          wg;
        logic          rg;
        logic [2:0]    cnt;
        logic          fu;
        logic          em;
        logic          af;
        logic          ov;
        logic          un;
        logic [DW-1:0] out;
    } obs_t;

    typedef struct packed {
        logic          wr;
        logic          rd;
        logic          fl;
        logic [DW-1:0] din;
        obs_t          exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n, flush, write_req, read_req;
    logic [DW-1:0] din;

    logic l_wgnt, l_rgnt, l_empty, l_full, l_af, l_ovf, l_unf;
    logic e_wgnt, e_rgnt, e_empty, e_full, e_af, e_ovf, e_unf;
    logic [DW-1:0] l_out, e_out;
    logic [2:0] l_count, e_count;
    obs_t ol, oe;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(3), .WR_EDGE_MODE(0)) dut_l (
        .clk(clk), .rst_n(rst_n), .flush(flush), .write_req(write_req), .PacketIn(din),
        .write_gnt(l_wgnt), .read_req(read_req), .read_gnt(l_rgnt), .PacketOut(l_out),
        .empty(l_empty), .full(l_full), .almost_full(l_af), .count(l_count),
        .overflow(l_ovf), .underflow(l_unf)
    );

    pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DP), .AF_THRESH(3), .WR_EDGE_MODE(1)) dut_e (
        .clk(clk), .rst_n(rst_n), .flush(flush), .write_req(write_req), .PacketIn(din),
        .write_gnt(e_wgnt), .read_req(read_req), .read_gnt(e_rgnt), .PacketOut(e_out),
        .empty(e_empty), .full(e_full), .almost_full(e_af), .count(e_count),
        .overflow(e_ovf), .underflow(e_unf)
    );

    assign ol = {l_wgnt, l_rgnt, l_count, l_full, l_empty, l_af, l_ovf, l_unf, l_out};
    assign oe = {e_wgnt, e_rgnt, e_count, e_full, e_empty, e_af, e_ovf, e_unf, e_out};

    // Reference model: an ordinary queue plus the acceptance rules stated as plain conditions.
    logic [DW-1:0] mq [2][$];
    logic m_arm [2];
    logic m_ov  [2];
    logic m_un  [2];
    logic m_wg  [2];
    logic m_rg  [2];
    logic [DW-1:0] m_out [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic cmp(input string tag, input obs_t a, input obs_t e);
        chk({tag, ".write_gnt"}, 32'(a.wg), 32'(e.wg));
        chk({tag, ".read_gnt"}, 32'(a.rg), 32'(e.rg));
        chk({tag, ".count"}, 32'(a.cnt), 32'(e.cnt));
        chk({tag, ".full"}, 32'(a.fu), 32'(e.fu));
        chk({tag, ".empty"}, 32'(a.em), 32'(e.em));
        chk({tag, ".almost_full"}, 32'(a.af), 32'(e.af));
        chk({tag, ".overflow"}, 32'(a.ov), 32'(e.ov));
        chk({tag, ".underflow"}, 32'(a.un), 32'(e.un));
        chk({tag, ".PacketOut"}, 32'(a.out), 32'(e.out));
    endtask

    function automatic obs_t mk(input logic wg, rg, input int cnt, input logic ov, un,
                                input logic [DW-1:0] out);
        obs_t o;
        o.wg = wg; o.rg = rg; o.cnt = 3'(cnt);
        o.fu = (cnt == DP); o.em = (cnt == 0); o.af = (cnt >= 3);
        o.ov = ov; o.un = un; o.out = out;
        return o;
    endfunction

    function automatic obs_t mobs(input int m);
        return mk(m_wg[m], m_rg[m], mq[m].size(), m_ov[m], m_un[m], m_out[m]);
    endfunction

    task automatic mreset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            m_arm[m] = 1'b1; m_ov[m] = 1'b0; m_un[m] = 1'b0;
            m_wg[m] = 1'b0; m_rg[m] = 1'b0; m_out[m] = '0;
        end
    endtask

    task automatic mstep(input int m);
        bit fu, em, en, wok, rok;
        fu = (mq[m].size() == DP);
        em = (mq[m].size() == 0);
        en = (m == 0) || m_arm[m];
        if (flush) begin
            mq[m].delete();
            m_ov[m] = 1'b0; m_un[m] = 1'b0; m_arm[m] = 1'b1;
            m_wg[m] = 1'b0; m_rg[m] = 1'b0;
        end else begin
            wok = write_req && !fu && en;
            rok = read_req && !em;
            if (write_req && fu && en) m_ov[m] = 1'b1;
            if (read_req && em) m_un[m] = 1'b1;
            if (rok) m_out[m] = mq[m].pop_front();
            if (wok) mq[m].push_back(din);
            if (!write_req) m_arm[m] = 1'b1;
            else if (wok) m_arm[m] = 1'b0;
            m_wg[m] = wok; m_rg[m] = rok;
        end
    endtask

    task automatic drive(input logic wr, rd, fl, input logic [DW-1:0] d);
        write_req = wr; read_req = rd; flush = fl; din = d;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, '0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    vec_t tv[$];
    vec_t v;
    int pulses;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, '0);
        tick();
        cmp("reset_l", ol, mk(0, 0, 0, 0, 0, '0));
        cmp("reset_e", oe, mk(0, 0, 0, 0, 0, '0));
        rst_n = 1'b1;

        // Fill/overflow, drain/underflow, flush, then simultaneous access at empty, mid and full.
        tv.push_back({1'b1, 1'b0, 1'b0, 16'h000A, mk(1, 0, 1, 0, 0, 16'h0)});
        tv.push_back({1'b1, 1'b0, 1'b0, 16'h000B, mk(1, 0, 2, 0, 0, 16'h0)});
        tv.push_back({1'b1, 1'b0, 1'b0, 16'h000C, mk(1, 0, 3, 0, 0, 16'h0)});
        tv.push_back({1'b1, 1'b0, 1'b0, 16'h000D, mk(1, 0, 4, 0, 0, 16'h0)});
        tv.push_back({1'b1, 1'b0, 1'b0, 16'h000E, mk(0, 0, 4, 1, 0, 16'h0)});
        tv.push_back({1'b0, 1'b1, 1'b0, 16'h0000, mk(0, 1, 3, 1, 0, 16'h000A)});
        tv.push_back({1'b0, 1'b1, 1'b0, 16'h0000, mk(0, 1, 2, 1, 0, 16'h000B)});
        tv.push_back({1'b0, 1'b1, 1'b0, 16'h0000, mk(0, 1, 1, 1, 0, 16'h000C)});
        tv.push_back({1'b0, 1'b1, 1'b0, 16'h0000, mk(0, 1, 0, 1, 0, 16'h000D)});
        tv.push_back({1'b0, 1'b1, 1'b0, 16'h0000, mk(0, 0, 0, 1, 1, 16'h000D)});
        tv.push_back({1'b1, 1'b0, 1'b1, 16'h00EE, mk(0, 0, 0, 0, 0, 16'h000D)});
        tv.push_back({1'b1, 1'b1, 1'b0, 16'h000F, mk(1, 0, 1, 0, 1, 16'h000D)});
        tv.push_back({1'b1, 1'b0, 1'b0, 16'h0010, mk(1, 0, 2, 0, 1, 16'h000D)});
        tv.push_back({1'b1, 1'b1, 1'b0, 16'h0011, mk(1, 1, 2, 0, 1, 16'h000F)});
        tv.push_back({1'b1, 1'b0, 1'b0, 16'h0012, mk(1, 0, 3, 0, 1, 16'h000F)});
        tv.push_back({1'b1, 1'b0, 1'b0, 16'h0013, mk(1, 0, 4, 0, 1, 16'h000F)});
        tv.push_back({1'b1, 1'b1, 1'b0, 16'h0014, mk(0, 1, 3, 1, 1, 16'h0010)});
        for (int i = 0; i < tv.size(); i++) begin
            v = tv[i];
            drive(v.wr, v.rd, v.fl, v.din);
            tick();
            cmp($sformatf("vec%0d", i), ol, v.exp);
        end

        // Address wrap: six write/read pairs through a four-entry FIFO.
        drive(0, 0, 1, '0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(1, 0, 0, 16'h0050 + 16'(i));
            tick();
            chk($sformatf("wrap%0d.full", i), 32'(l_full), 32'd0);
            drive(0, 1, 0, '0);
            tick();
            chk($sformatf("wrap%0d.read_gnt", i), 32'(l_rgnt), 32'd1);
            chk($sformatf("wrap%0d.PacketOut", i), 32'(l_out), 32'h50 + 32'(i));
        end
        chk("wrap.count", 32'(l_count), 32'd0);

        // Edge mode: held request earns one grant, re-arms after a low cycle.
        do_reset();
        pulses = 0;
        for (int i = 0; i < 9; i++) begin
            drive((i < 5) || (i == 6), 0, 0, 16'h0100 + 16'(i));
            tick();
            pulses += int'(e_wgnt);
        end
        chk("edge.pulses", 32'(pulses), 32'd2);
        chk("edge.count", 32'(e_count), 32'd2);
        chk("edge.overflow", 32'(e_ovf), 32'd0);

        // Flush with a concurrent write, then asynchronous reset in the middle of a read.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 16'h0060 + 16'(i));
            tick();
        end
        drive(1, 0, 1, 16'h00AA);
        tick();
        cmp("flush", ol, mk(0, 0, 0, 0, 0, '0));
        drive(1, 0, 0, 16'h0077);
        tick();
        drive(0, 0, 0, '0);
        tick();
        drive(1, 0, 0, 16'h0078);
        tick();
        drive(0, 1, 0, '0);
        @(posedge clk);
        #1;
        cmp("pre_rst", ol, mk(0, 1, 1, 0, 0, 16'h0077));
        #1 rst_n = 1'b0;
        #1;
        cmp("async_rst_l", ol, mk(0, 0, 0, 0, 0, '0));
        cmp("async_rst_e", oe, mk(0, 0, 0, 0, 0, '0));
        @(negedge clk);
        drive(0, 0, 0, '0);
        rst_n = 1'b1;
        drive(1, 0, 0, 16'h0099);
        tick();
        drive(0, 1, 0, '0);
        tick();
        cmp("post_rst", ol, mk(0, 1, 0, 0, 0, 16'h0099));

        // Random traffic against the queue model on both write modes.
        do_reset();
        mreset();
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(99) < 60, $urandom_range(99) < 50,
                  $urandom_range(99) < 3, 16'($urandom));
            @(posedge clk);
            mstep(0);
            mstep(1);
            @(negedge clk);
            cmp($sformatf("rnd%0d_l", i), ol, mobs(0));
            cmp($sformatf("rnd%0d_e", i), oe, mobs(1));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
